vliw_scoreboard: RTL and testbench

//   Parametrised issue-hazard unit for the N-slot VLIW pipeline; successor to the fixed 2-slot

---
 rtl/vliw_scoreboard_pkg.sv | 19 +
 rtl/vliw_scoreboard_if.sv | 36 +++
 rtl/vliw_scoreboard_sb_entry.sv | 29 ++
 rtl/vliw_scoreboard.sv | 103 ++++++++++
 tb/tb_vliw_scoreboard.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/vliw_scoreboard_pkg.sv
// Shared defaults, hazard-cause encoding and slot field helpers for the
// VLIW issue scoreboard.
package vliw_scoreboard_pkg;
  localparam int NUM_SLOTS_D = 2;
  localparam int REG_ID_W_D  = 4;
  localparam int LAT_W_D     = 2;
  localparam int CNT_W_D     = 16;

  // Stall cause: both bits may be set when a bundle has RAW and WAW hazards.
  typedef struct packed {
    logic raw;
    logic waw;
  } hz_t;

  // Base bit offset of slot s in a flat per-slot field of width w.
  function automatic int unsigned fld(input int unsigned s, input int unsigned w);
    return s * w;
  endfunction
endpackage

// File: rtl/vliw_scoreboard_if.sv
// Decode-to-scoreboard bundle interface. master = decode stage, slave = scoreboard.
interface vliw_scoreboard_if #(
  parameter int NUM_SLOTS = vliw_scoreboard_pkg::NUM_SLOTS_D,
  parameter int REG_ID_W  = vliw_scoreboard_pkg::REG_ID_W_D,
  parameter int NUM_REGS  = 2**REG_ID_W,
  parameter int LAT_W     = vliw_scoreboard_pkg::LAT_W_D,
  parameter int CNT_W     = vliw_scoreboard_pkg::CNT_W_D
);
  logic [NUM_SLOTS-1:0]          issue_valid;
  logic [NUM_SLOTS*REG_ID_W-1:0] src_a_id;
  logic [NUM_SLOTS-1:0]          src_a_use;
  logic [NUM_SLOTS*REG_ID_W-1:0] src_b_id;
  logic [NUM_SLOTS-1:0]          src_b_use;
  logic [NUM_SLOTS*REG_ID_W-1:0] dst_id;
  logic [NUM_SLOTS-1:0]          dst_wr;
  logic [NUM_SLOTS*LAT_W-1:0]    dst_lat;
  logic                          flush;
  logic                          issue_ready;
  logic                          stall_raw;
  logic                          stall_waw;
  logic [NUM_REGS-1:0]           busy;
  logic                          bundle_err;
  logic [CNT_W-1:0]              stall_count;

  modport master (
    output issue_valid, src_a_id, src_a_use, src_b_id, src_b_use,
           dst_id, dst_wr, dst_lat, flush,
    input  issue_ready, stall_raw, stall_waw, busy, bundle_err, stall_count
  );

  modport slave (
    input  issue_valid, src_a_id, src_a_use, src_b_id, src_b_use,
           dst_id, dst_wr, dst_lat, flush,
    output issue_ready, stall_raw, stall_waw, busy, bundle_err, stall_count
  );
endinterface

// File: rtl/vliw_scoreboard_sb_entry.sv
// One register's readiness countdown: load wins over decrement, idles at zero.
module sb_entry #(
  parameter int LAT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [LAT_W-1:0] lat_i,
  output logic [LAT_W-1:0] cnt_o,
  output logic             busy_o
);
  logic [LAT_W-1:0] cnt_q, cnt_d;

  // Next count: new latency on load, otherwise count down to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)              cnt_d = lat_i;
    else if (cnt_q != '0)    cnt_d = cnt_q - LAT_W'(1);
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign busy_o = (cnt_q != '0);
endmodule

// File: rtl/vliw_scoreboard.sv
// Bundle issue gate for the N-slot VLIW pipeline: RAW/WAW hazard detection
// against per-register countdowns, whole-bundle issue, stall counter.
module vliw_scoreboard #(
  parameter int NUM_SLOTS = vliw_scoreboard_pkg::NUM_SLOTS_D,
  parameter int REG_ID_W  = vliw_scoreboard_pkg::REG_ID_W_D,
  parameter int NUM_REGS  = 2**REG_ID_W,
  parameter int LAT_W     = vliw_scoreboard_pkg::LAT_W_D,
  parameter int CNT_W     = vliw_scoreboard_pkg::CNT_W_D
) (
  input logic              clk,
  input logic              reset,
  vliw_scoreboard_if.slave sb
);
  import vliw_scoreboard_pkg::*;

  logic [NUM_REGS-1:0][LAT_W-1:0] cnt;
  logic [NUM_REGS-1:0][LAT_W-1:0] load_lat;
  logic [NUM_REGS-1:0]            load;
  logic [NUM_REGS-1:0]            busy;
  hz_t                            hz;
  logic                           ready, fire, dup, stall_inc;
  logic [CNT_W-1:0]               stall_cnt_q, stall_cnt_d;
  logic                           err_q, err_d;

  // Hazards are judged against pre-bundle state only, so slots never see
  // each other's destinations (no intra-bundle RAW).
  always_comb begin
    hz = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (sb.issue_valid[s]) begin
        if (sb.src_a_use[s] && cnt[sb.src_a_id[fld(s, REG_ID_W) +: REG_ID_W]] != '0)
          hz.raw = 1'b1;
        if (sb.src_b_use[s] && cnt[sb.src_b_id[fld(s, REG_ID_W) +: REG_ID_W]] != '0)
          hz.raw = 1'b1;
        // Older result landing after this one would clobber it.
        if (sb.dst_wr[s] &&
            cnt[sb.dst_id[fld(s, REG_ID_W) +: REG_ID_W]] > sb.dst_lat[fld(s, LAT_W) +: LAT_W])
          hz.waw = 1'b1;
      end
    end
    if (reset) hz = '0;
  end

  assign ready     = !reset && !sb.flush && !hz.raw && !hz.waw;
  assign fire      = ready && (|sb.issue_valid);
  assign stall_inc = (|sb.issue_valid) && !ready && !sb.flush && !reset;

  // Destination load decode; later slots overwrite earlier ones so the
  // highest-numbered writer's latency wins. Zero latency creates no entry.
  always_comb begin
    load     = '0;
    load_lat = '0;
    dup      = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (fire && sb.issue_valid[s] && sb.dst_wr[s] &&
          sb.dst_lat[fld(s, LAT_W) +: LAT_W] != '0) begin
        load[sb.dst_id[fld(s, REG_ID_W) +: REG_ID_W]]     = 1'b1;
        load_lat[sb.dst_id[fld(s, REG_ID_W) +: REG_ID_W]] = sb.dst_lat[fld(s, LAT_W) +: LAT_W];
      end
      for (int t = s + 1; t < NUM_SLOTS; t++) begin
        if (sb.issue_valid[s] && sb.dst_wr[s] && sb.issue_valid[t] && sb.dst_wr[t] &&
            sb.dst_id[fld(s, REG_ID_W) +: REG_ID_W] == sb.dst_id[fld(t, REG_ID_W) +: REG_ID_W])
          dup = 1'b1;
      end
    end
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_entry
    sb_entry #(.LAT_W(LAT_W)) u_entry (
      .clk    (clk),
      .reset  (reset),
      .load_i (load[r]),
      .lat_i  (load_lat[r]),
      .cnt_o  (cnt[r]),
      .busy_o (busy[r])
    );
  end

  // Saturating stall counter and sticky duplicate-destination flag.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_inc && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    err_d = err_q | (fire & dup);
  end

  // Performance/debug state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  assign sb.issue_ready = ready;
  assign sb.stall_raw   = hz.raw;
  assign sb.stall_waw   = hz.waw;
  assign sb.busy        = busy;
  assign sb.bundle_err  = err_q;
  assign sb.stall_count = stall_cnt_q;
endmodule

// File: tb/tb_vliw_scoreboard.sv
// Directed bench for vliw_scoreboard: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_vliw_scoreboard;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vliw_scoreboard_if #(.NUM_SLOTS(2), .REG_ID_W(4), .NUM_REGS(16), .LAT_W(2), .CNT_W(4)) bus ();

  vliw_scoreboard #(.NUM_SLOTS(2), .REG_ID_W(4), .NUM_REGS(16), .LAT_W(2), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (bus)
  );

  typedef struct {
    string       nm;
    logic        ready, raw, waw;
    logic [15:0] busy;
    logic        err;
    logic [3:0]  cnt;
  } exp_t;

  exp_t q[$];
  int   npass = 0;
  int   ntotal = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    ntotal++;
    if (act === req) npass++;
    else $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, req);
  endtask

  // Monitor: compare whatever the stimulus expects for this cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "issue_ready", 32'(bus.issue_ready), 32'(e.ready));
      chk(e.nm, "stall_raw",   32'(bus.stall_raw),   32'(e.raw));
      chk(e.nm, "stall_waw",   32'(bus.stall_waw),   32'(e.waw));
      chk(e.nm, "busy",        32'(bus.busy),        32'(e.busy));
      chk(e.nm, "bundle_err",  32'(bus.bundle_err),  32'(e.err));
      chk(e.nm, "stall_count", 32'(bus.stall_count), 32'(e.cnt));
    end
  end

  task automatic idle();
    bus.issue_valid = '0; bus.src_a_id = '0; bus.src_a_use = '0;
    bus.src_b_id = '0; bus.src_b_use = '0; bus.dst_id = '0;
    bus.dst_wr = '0; bus.dst_lat = '0; bus.flush = 1'b0;
  endtask

  task automatic wr_slot(input int s, input logic [3:0] d, input logic [1:0] lat);
    bus.issue_valid[s] = 1'b1; bus.dst_wr[s] = 1'b1;
    bus.dst_id[s*4 +: 4] = d;  bus.dst_lat[s*2 +: 2] = lat;
  endtask

  task automatic rd_a(input int s, input logic [3:0] r);
    bus.issue_valid[s] = 1'b1; bus.src_a_use[s] = 1'b1; bus.src_a_id[s*4 +: 4] = r;
  endtask

  task automatic rd_b(input int s, input logic [3:0] r);
    bus.issue_valid[s] = 1'b1; bus.src_b_use[s] = 1'b1; bus.src_b_id[s*4 +: 4] = r;
  endtask

  // Expectation for the cycle just set up, then advance one clock.
  task automatic step(input string nm, input logic rdy, input logic raw, input logic waw,
                      input logic [15:0] bsy, input logic err, input logic [3:0] cn);
    exp_t e;
    e.nm = nm; e.ready = rdy; e.raw = raw; e.waw = waw;
    e.busy = bsy; e.err = err; e.cnt = cn;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    @(posedge clk); #1;
    step("reset",      0, 0, 0, 16'h0000, 0, 0);

    // Reset mid-operation
    reset = 1'b0;
    idle(); wr_slot(0, 4'd3, 2'd3);
    step("t1_load",    1, 0, 0, 16'h0000, 0, 0);
    idle(); rd_a(1, 4'd3);
    step("t1_raw",     0, 1, 0, 16'h0008, 0, 0);
    reset = 1'b1;
    step("t1_rst",     0, 0, 0, 16'h0008, 0, 1);
    reset = 1'b0; idle();
    step("t1_after",   1, 0, 0, 16'h0000, 0, 0);

    // RAW for exactly dst_lat cycles
    idle(); wr_slot(0, 4'd5, 2'd2);
    step("t2_load",    1, 0, 0, 16'h0000, 0, 0);
    idle(); rd_a(1, 4'd5);
    step("t2_raw1",    0, 1, 0, 16'h0020, 0, 0);
    step("t2_raw2",    0, 1, 0, 16'h0020, 0, 1);
    step("t2_go",      1, 0, 0, 16'h0000, 0, 2);

    // WAW stall, then reload with equal latency
    idle(); wr_slot(0, 4'd2, 2'd3);
    step("t3_load",    1, 0, 0, 16'h0000, 0, 2);
    idle(); wr_slot(0, 4'd2, 2'd1);
    step("t3_waw",     0, 0, 1, 16'h0004, 0, 2);
    idle(); wr_slot(0, 4'd2, 2'd3);
    step("t3_reload",  1, 0, 0, 16'h0004, 0, 3);
    idle(); wr_slot(0, 4'd2, 2'd2);
    step("t3_probe",   0, 0, 1, 16'h0004, 0, 3);
    idle();
    step("t3_c2",      1, 0, 0, 16'h0004, 0, 4);
    step("t3_c1",      1, 0, 0, 16'h0004, 0, 4);
    step("t3_c0",      1, 0, 0, 16'h0000, 0, 4);

    // Same destination in one bundle: slot 1 latency wins, sticky error
    idle(); wr_slot(0, 4'd7, 2'd1); wr_slot(1, 4'd7, 2'd3);
    step("t4_dup",     1, 0, 0, 16'h0000, 0, 4);
    idle(); wr_slot(0, 4'd7, 2'd2);
    step("t4_probe",   0, 0, 1, 16'h0080, 1, 4);
    idle();
    step("t4_c2",      1, 0, 0, 16'h0080, 1, 5);
    step("t4_c1",      1, 0, 0, 16'h0080, 1, 5);
    step("t4_sticky",  1, 0, 0, 16'h0000, 1, 5);

    // Flush during a pending RAW
    idle(); wr_slot(0, 4'd5, 2'd3);
    step("t5_load",    1, 0, 0, 16'h0000, 1, 5);
    idle(); rd_b(1, 4'd5); bus.flush = 1'b1;
    step("t5_flush1",  0, 1, 0, 16'h0020, 1, 5);
    step("t5_flush2",  0, 1, 0, 16'h0020, 1, 5);
    bus.flush = 1'b0;
    step("t5_raw",     0, 1, 0, 16'h0020, 1, 5);
    step("t5_go",      1, 0, 0, 16'h0000, 1, 6);

    // Saturation: self-dependent bundle stalls 3 of every 4 cycles
    idle(); rd_a(0, 4'd6); wr_slot(0, 4'd6, 2'd3);
    repeat (28) begin @(posedge clk); #1; end
    idle();
    step("t6_sat",     1, 0, 0, 16'h0000, 1, 15);
    wr_slot(0, 4'd6, 2'd3);
    step("t6_load",    1, 0, 0, 16'h0000, 1, 15);
    idle(); rd_a(0, 4'd6);
    step("t6_hold",    0, 1, 0, 16'h0040, 1, 15);
    idle();
    step("t6_end",     1, 0, 0, 16'h0040, 1, 15);

    // Reset clears sticky error and counter
    reset = 1'b1;
    step("rst_end",    0, 0, 0, 16'h0040, 1, 15);
    reset = 1'b0;
    step("rst_clear",  1, 0, 0, 16'h0000, 0, 0);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      ntotal++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
